// File: rtl/eigen_portfolio_ranked.sv
// Picks the eigenvector whose eigenvalue has a run-time rank (0 = largest) and
// scales it so its weights sum to 1.0, using one shared serial restoring divider.
module eigen_portfolio_ranked #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter int N_STOCKS = 3,
  parameter int RANK_W   = $clog2(N_STOCKS) + 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [RANK_W-1:0]                     rank_sel,
  input  logic signed [N_STOCKS*N_STOCKS*WIDTH-1:0] eigenvectors,
  input  logic signed [N_STOCKS*WIDTH-1:0]      eigenvalues,
  output logic                                  busy,
  output logic                                  done,
  output logic signed [N_STOCKS*WIDTH-1:0]      portfolio,
  output logic                                  err_rank,
  output logic                                  err_zero,
  output logic                                  overflow
);

  localparam int IDX_W = $clog2(N_STOCKS);
  localparam int SUM_W = WIDTH + $clog2(N_STOCKS);
  localparam int QW    = WIDTH + FRAC;
  localparam int CNT_W = $clog2(QW + 1);
  localparam int REM_W = SUM_W + 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STOCKS - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(QW);
  localparam logic [QW-1:0]    MIN_MAG  = QW'(64'd1 << (WIDTH - 1));
  localparam logic [QW-1:0]    MAX_MAG  = MIN_MAG - 1'b1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SELECT = 3'd1;
  localparam logic [2:0] S_SUM    = 3'd2;
  localparam logic [2:0] S_DIV    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]                          r_state;
  logic [RANK_W-1:0]                   r_rank;
  logic [N_STOCKS*WIDTH-1:0]           r_ev;
  logic [N_STOCKS*N_STOCKS*WIDTH-1:0]  r_vec;
  logic [IDX_W-1:0]                    r_idx;
  logic [IDX_W-1:0]                    r_col;
  logic signed [SUM_W-1:0]             r_sum;
  logic [CNT_W-1:0]                    r_cnt;
  logic [REM_W-1:0]                    r_rem;
  logic [QW-1:0]                       r_quo;
  logic [SUM_W-1:0]                    r_div;
  logic                                r_neg;
  logic [N_STOCKS*WIDTH-1:0]           r_shadow;
  logic [N_STOCKS*WIDTH-1:0]           r_portfolio;
  logic                                r_err_rank;
  logic                                r_err_zero;
  logic                                r_ovf;

  logic [RANK_W-1:0]                   w_rank;
  logic signed [WIDTH-1:0]             w_ev_cur;
  logic signed [WIDTH-1:0]             w_v;
  logic [WIDTH-1:0]                    w_v_mag;
  logic [SUM_W-1:0]                    w_sum_mag;
  logic [REM_W-1:0]                    w_rem_sh;
  logic                                w_ge;
  logic [REM_W-1:0]                    w_rem_nx;
  logic [QW-1:0]                       w_quo_nx;
  logic [WIDTH-1:0]                    w_weight;
  logic                                w_sat;
  logic [N_STOCKS*WIDTH-1:0]           w_shadow_upd;

  // Rank of candidate r_idx: strictly larger values, plus equal values at lower index.
  // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_ev_cur = $signed(r_ev[int'(r_idx)*WIDTH +: WIDTH]);
    w_rank   = '0;
    for (int j = 0; j < N_STOCKS; j++) begin
      if (($signed(r_ev[j*WIDTH +: WIDTH]) > w_ev_cur) ||
          ((j < int'(r_idx)) && ($signed(r_ev[j*WIDTH +: WIDTH]) == w_ev_cur)))
        w_rank = w_rank + 1'b1;
    end
  end

  // Element (row r_idx, selected column) feeds both the sum and the divider load.
  assign w_v       = $signed(r_vec[(int'(r_idx)*N_STOCKS + int'(r_col))*WIDTH +: WIDTH]);
  assign w_v_mag   = w_v[WIDTH-1] ? (~w_v + 1'b1) : w_v;
  assign w_sum_mag = r_sum[SUM_W-1] ? (~r_sum + 1'b1) : r_sum;

  assign w_rem_sh = {r_rem[REM_W-2:0], r_quo[QW-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_div});
  assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_div}) : w_rem_sh;
  assign w_quo_nx = {r_quo[QW-2:0], w_ge};

  always_comb begin
    w_sat    = 1'b0;
    w_weight = '0;
    if (r_neg) begin
      if (w_quo_nx > MIN_MAG) begin
        w_sat    = 1'b1;
        w_weight = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        w_weight = ~w_quo_nx[WIDTH-1:0] + 1'b1;
      end
    end else if (w_quo_nx > MAX_MAG) begin
      w_sat    = 1'b1;
      w_weight = {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      w_weight = w_quo_nx[WIDTH-1:0];
    end
    w_shadow_upd = r_shadow;
    w_shadow_upd[int'(r_idx)*WIDTH +: WIDTH] = w_weight;
  end

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rank      <= '0;
      r_ev        <= '0;
      r_vec       <= '0;
      r_idx       <= '0;
      r_col       <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_neg       <= 1'b0;
      r_shadow    <= '0;
      r_portfolio <= '0;
      r_err_rank  <= 1'b0;
      r_err_zero  <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rank     <= rank_sel;
            r_ev       <= eigenvalues;
            r_vec      <= eigenvectors;
            r_idx      <= '0;
            r_col      <= '0;
            r_sum      <= '0;
            r_err_rank <= 1'b0;
            r_err_zero <= 1'b0;
            r_ovf      <= 1'b0;
            r_state    <= S_SELECT;
          end
        end
        S_SELECT: begin
          if (r_rank >= RANK_W'(N_STOCKS)) begin
            r_err_rank  <= 1'b1;
            r_portfolio <= '0;
            r_state     <= S_DONE;
          end else begin
            if (w_rank == r_rank) r_col <= r_idx;
            if (r_idx == LAST_IDX) begin
              r_idx   <= '0;
              r_state <= S_SUM;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_SUM: begin
          r_sum <= r_sum + SUM_W'(w_v);
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_state <= S_DIV;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DIV: begin
          if (r_cnt == '0) begin
            if (r_sum == '0) begin
              r_err_zero  <= 1'b1;
              r_portfolio <= '0;
              r_state     <= S_DONE;
            end else begin
              r_rem <= '0;
              r_quo <= QW'(w_v_mag) << FRAC;
              r_div <= w_sum_mag;
              r_neg <= w_v[WIDTH-1] ^ r_sum[SUM_W-1];
              r_cnt <= 1'b1;
            end
          end else begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            if (r_cnt == LAST_CNT) begin
              r_shadow <= w_shadow_upd;
              if (w_sat) r_ovf <= 1'b1;
              r_cnt <= '0;
              if (r_idx == LAST_IDX) begin
                r_portfolio <= w_shadow_upd;
                r_state     <= S_DONE;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign portfolio = r_portfolio;
  assign err_rank  = r_err_rank;
  assign err_zero  = r_err_zero;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_eigen_portfolio_ranked.sv
// Bench for eigen_portfolio_ranked: directed and random runs against a sorting /
// integer-division reference model, plus handshake and mid-run reset scenarios.
module tb_eigen_portfolio_ranked;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int F  = 8;
  localparam int RW = $clog2(N) + 1;
  localparam int LAT_FULL = 2*N + N*(W+F+1) + 1;

  logic                       clk;
  logic                       rst_n;
  logic                       start;
  logic [RW-1:0]              rank_sel;
  logic signed [N*N*W-1:0]    eigenvectors;
  logic signed [N*W-1:0]      eigenvalues;
  logic                       busy;
  logic                       done;
  logic signed [N*W-1:0]      portfolio;
  logic                       err_rank;
  logic                       err_zero;
  logic                       overflow;

  int checks = 0;
  int errors = 0;

  logic signed [W-1:0] g_ev  [N];
  logic signed [W-1:0] g_vec [N*N];
  int                  g_rank;

  logic signed [W-1:0] exp_port [N];
  logic                exp_er, exp_ez, exp_ov;
  int                  exp_lat;

  eigen_portfolio_ranked #(.WIDTH(W), .FRAC(F), .N_STOCKS(N), .RANK_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rank_sel(rank_sel),
    .eigenvectors(eigenvectors), .eigenvalues(eigenvalues),
    .busy(busy), .done(done), .portfolio(portfolio),
    .err_rank(err_rank), .err_zero(err_zero), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Reference: stable descending sort picks the column; weights by plain integer division.
  task automatic model();
    int  order [N];
    int  key, j, col;
    longint sum, q;
    for (int i = 0; i < N; i++) order[i] = i;
    for (int i = 1; i < N; i++) begin
      key = order[i];
      j = i - 1;
      while (j >= 0 && g_ev[order[j]] < g_ev[key]) begin
        order[j+1] = order[j];
        j--;
      end
      order[j+1] = key;
    end
    exp_er = 1'b0; exp_ez = 1'b0; exp_ov = 1'b0;
    for (int i = 0; i < N; i++) exp_port[i] = '0;
    if (g_rank >= N) begin
      exp_er  = 1'b1;
      exp_lat = 2;
      return;
    end
    col = order[g_rank];
    sum = 0;
    for (int r = 0; r < N; r++) sum += longint'(g_vec[r*N+col]);
    if (sum == 0) begin
      exp_ez  = 1'b1;
      exp_lat = 2*N + 2;
      return;
    end
    exp_lat = LAT_FULL;
    for (int r = 0; r < N; r++) begin
      q = (longint'(g_vec[r*N+col]) * (longint'(1) << F)) / sum;
      if (q > 32767) begin q = 32767; exp_ov = 1'b1; end
      else if (q < -32768) begin q = -32768; exp_ov = 1'b1; end
      exp_port[r] = W'(q);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) eigenvalues[i*W +: W] = g_ev[i];
    for (int i = 0; i < N*N; i++) eigenvectors[i*W +: W] = g_vec[i];
    rank_sel = RW'(g_rank);
  endtask

  // Accepts one run, waits (bounded) for done, and compares latency, weights and flags.
  task automatic run_case(input string name);
    int cyc;
    model();
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end
    cyc = 1;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checks++;
    if (cyc !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (portfolio[i*W +: W] !== exp_port[i]) begin
        errors++;
        $display("FAIL %s weight[%0d]: got %h want %h", name, i, portfolio[i*W +: W], exp_port[i]);
      end
    end
    checks++;
    if ({err_rank, err_zero, overflow} !== {exp_er, exp_ez, exp_ov}) begin
      errors++;
      $display("FAIL %s flags(rank,zero,ovf): got %b want %b", name,
               {err_rank, err_zero, overflow}, {exp_er, exp_ez, exp_ov});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL %s idle_after_done(done,busy): got %b want 00", name, {done, busy});
    end
  endtask

  task automatic set_vec(input logic [W-1:0] c0, input logic [W-1:0] c1, input logic [W-1:0] c2,
                         input int col);
    g_vec[0*N+col] = c0;
    g_vec[1*N+col] = c1;
    g_vec[2*N+col] = c2;
  endtask

  task automatic fill_other_columns();
    for (int i = 0; i < N*N; i++) g_vec[i] = W'($urandom_range(0, 16'h0400));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rank_sel = '0; eigenvectors = '0; eigenvalues = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err_rank, err_zero, overflow} !== 5'b0 || portfolio !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy/done/flags %b portfolio %h want all zero",
               {busy, done, err_rank, err_zero, overflow}, portfolio);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    fill_other_columns();
    g_ev[0] = 16'h0300; g_ev[1] = 16'h0100; g_ev[2] = 16'h0200;
    set_vec(16'h0100, 16'h0100, 16'h0200, 2);
    g_rank = 1;
    run_case("basic");
    checks++;
    if (portfolio !== {16'sh0080, 16'sh0040, 16'sh0040}) begin
      errors++;
      $display("FAIL basic_constant: got %h want 008000400040", portfolio);
    end
  endtask

  task automatic test_sign();
    fill_other_columns();
    g_ev[0] = 16'h0500; g_ev[1] = 16'h0100; g_ev[2] = 16'h0200;
    set_vec(16'hFF00, 16'h0200, 16'h0300, 0);
    g_rank = 0;
    run_case("sign");
  endtask

  task automatic test_overflow();
    fill_other_columns();
    g_ev[0] = 16'h0100; g_ev[1] = 16'h0700; g_ev[2] = 16'h0200;
    set_vec(16'h6400, 16'h9C80, 16'h0000, 1);
    g_rank = 0;
    run_case("overflow");
  endtask

  task automatic test_zero_sum();
    fill_other_columns();
    g_ev[0] = 16'h0100; g_ev[1] = 16'h0200; g_ev[2] = 16'h0300;
    set_vec(16'h0100, 16'hFF00, 16'h0000, 2);
    g_rank = 0;
    run_case("zero_sum");
  endtask

  task automatic test_bad_rank();
    fill_other_columns();
    g_ev[0] = 16'h0100; g_ev[1] = 16'h0200; g_ev[2] = 16'h0300;
    g_rank = 3;
    run_case("bad_rank");
  endtask

  task automatic test_ties();
    fill_other_columns();
    for (int i = 0; i < N; i++) g_ev[i] = 16'h0100;
    set_vec(16'h0100, 16'h0100, 16'h0200, 2);
    set_vec(16'h0200, 16'h0200, 16'h0400, 0);
    g_rank = 2;
    run_case("ties");
  endtask

  task automatic test_random();
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < N; i++) g_ev[i] = W'($urandom_range(0, 3) * 16'h0100 - 16'h0100);
      for (int i = 0; i < N*N; i++)
        g_vec[i] = (t % 3 == 0) ? W'($urandom) : W'($urandom_range(0, 16'h0600) - 16'h0300);
      g_rank = (t % 8 == 7) ? N + int'($urandom_range(0, 4)) : int'($urandom_range(0, N-1));
      run_case("random");
    end
  endtask

  // Extra start pulses with different inputs mid-run must neither queue nor disturb the run.
  task automatic test_busy_start();
    int n_done;
    fill_other_columns();
    g_ev[0] = 16'h0300; g_ev[1] = 16'h0100; g_ev[2] = 16'h0200;
    set_vec(16'h0100, 16'h0300, 16'h0200, 0);
    g_rank = 0;
    model();
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    for (int c = 1; c <= 200; c++) begin
      if (done) n_done++;
      if (c == 5 || c == 30) begin
        start = 1'b1;
        rank_sel = 2'd2;
        eigenvalues = '0;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL busy_start done_pulses: got %0d want 1", n_done);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (portfolio[i*W +: W] !== exp_port[i]) begin
        errors++;
        $display("FAIL busy_start weight[%0d]: got %h want %h", i, portfolio[i*W +: W], exp_port[i]);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_start idle: got busy %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    int n_done;
    fill_other_columns();
    g_ev[0] = 16'h0100; g_ev[1] = 16'h0300; g_ev[2] = 16'h0200;
    set_vec(16'h0080, 16'h0100, 16'h0180, 1);
    g_rank = 0;
    @(negedge clk);
    drive_inputs();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (39) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || portfolio !== '0) begin
      errors++;
      $display("FAIL reset_mid state: got busy/done %b portfolio %h want 00 and zeros",
               {busy, done}, portfolio);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL reset_mid spurious_done: got %0d want 0", n_done);
    end
    run_case("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_overflow();
    test_zero_sum();
    test_bad_rank();
    test_ties();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
